decap_stage_sequencer: RTL and testbench

Top-level controller for the decapsulation decryption datapath. After one `start` pulse it runs the four stages in order: additive FFT syndrome, doubled syndrome, Berlekamp-Massey, error locator. Each stage gets a one-cycle start pulse and the sequencer waits for that stage's done. It also owns the shared P-memory read port, granting it to the FFT/syndrome stage or the error-locator stage according to the current state. It adds a per-stage watchdog and aggregates failure status.

---
 rtl/decap_stage_sequencer.sv | 112 +++++++++++
 tb/tb_decap_stage_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/decap_stage_sequencer.sv
// decap_stage_sequencer: runs FFT, syndrome, BM and locator stages with watchdog, abort and P-port arbitration.
// Optional feature macro DECAP_PROFILE_EN adds per-stage cycle counters.
module decap_stage_sequencer #(
    parameter int unsigned m = 13,
    parameter int unsigned TO_W = 20,
    parameter logic [TO_W-1:0] STAGE_TIMEOUT = 20'hFFFFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic         fail,
    output logic [2:0]   fail_code,
    output logic [2:0]   stage,
    output logic         fft_start,
    output logic         synd_start,
    output logic         bm_start,
    output logic         loc_start,
    input  logic         fft_done,
    input  logic         synd_done,
    input  logic         bm_done,
    input  logic         loc_done,
    input  logic         loc_fail,
    input  logic         fft_rd_en,
    input  logic [m-1:0] fft_rd_addr,
    input  logic         loc_rd_en,
    input  logic [m-1:0] loc_rd_addr,
`ifdef DECAP_PROFILE_EN
    output logic [31:0]  cyc_total,
    output logic [31:0]  cyc_fft,
    output logic [31:0]  cyc_synd,
    output logic [31:0]  cyc_bm,
    output logic [31:0]  cyc_loc,
`endif
    output logic         P_rd_en,
    output logic [m-1:0] P_rd_addr
);
    typedef enum logic [2:0] {IDLE = 3'd0, FFT = 3'd1, SYND = 3'd2, BM = 3'd3, LOC = 3'd4, FIN = 3'd5} state_t;
    state_t st, nx;
    logic [TO_W-1:0] wd;
    logic active, adv;
    logic [2:0] code;
    assign active = st == FFT || st == SYND || st == BM || st == LOC;
    assign busy = active;
    assign done = st == FIN;
    assign stage = st;
    assign P_rd_en = (st == FFT || st == SYND) ? fft_rd_en : st == LOC ? loc_rd_en : 1'b0;
    assign P_rd_addr = (st == FFT || st == SYND) ? fft_rd_addr : st == LOC ? loc_rd_addr : '0;
    // A done coinciding with its own start pulse is ignored; priority is abort, then done, then timeout.
    always_comb begin
        adv = (st == FFT && fft_done && !fft_start) || (st == SYND && synd_done && !synd_start)
           || (st == BM && bm_done && !bm_start) || (st == LOC && loc_done && !loc_start);
        code = abort ? 3'd3 : adv ? {2'b00, loc_fail} : 3'd2;
        nx = st;
        if (st == IDLE) nx = start ? FFT : IDLE;
        else if (st == FIN) nx = IDLE;
        else if (abort) nx = FIN;
        else if (adv) nx = state_t'(st + 3'd1);
        else if (wd == STAGE_TIMEOUT) nx = FIN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
            wd <= '0;
            fail <= 1'b0;
            fail_code <= 3'd0;
            fft_start <= 1'b0;
            synd_start <= 1'b0;
            bm_start <= 1'b0;
            loc_start <= 1'b0;
        end else begin
            st <= nx;
            wd <= (nx != st || !active) ? '0 : wd + TO_W'(1);
            fft_start <= st == IDLE && start;
            synd_start <= st == FFT && nx == SYND;
            bm_start <= st == SYND && nx == BM;
            loc_start <= st == BM && nx == LOC;
            if (st == IDLE && start) begin
                fail <= 1'b0;
                fail_code <= 3'd0;
            end else if (active && nx == FIN) begin
                fail <= code != 3'd0;
                fail_code <= code;
            end
        end
    end
`ifdef DECAP_PROFILE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_total <= '0;
            cyc_fft <= '0;
            cyc_synd <= '0;
            cyc_bm <= '0;
            cyc_loc <= '0;
        end else if (st == IDLE && start) begin
            cyc_total <= '0;
            cyc_fft <= '0;
            cyc_synd <= '0;
            cyc_bm <= '0;
            cyc_loc <= '0;
        end else begin
            if (st != IDLE) cyc_total <= cyc_total + 32'd1;
            if (st == FFT) cyc_fft <= cyc_fft + 32'd1;
            if (st == SYND) cyc_synd <= cyc_synd + 32'd1;
            if (st == BM) cyc_bm <= cyc_bm + 32'd1;
            if (st == LOC) cyc_loc <= cyc_loc + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_decap_stage_sequencer.sv
// tb_decap_stage_sequencer: scoreboard bench; scenarios are expanded into per-cycle stimulus and expected events.
module tb_decap_stage_sequencer;
    localparam int T = 50;
    logic clk = 0, rst_n = 0, start = 0, abort = 0, loc_fail = 0;
    logic fft_done = 0, synd_done = 0, bm_done = 0, loc_done = 0;
    logic fft_rd_en = 0, loc_rd_en = 0;
    logic [12:0] fft_rd_addr = 0, loc_rd_addr = 0, P_rd_addr;
    logic busy, done, fail, fft_start, synd_start, bm_start, loc_start, P_rd_en;
    logic [2:0] fail_code, stage;
`ifdef DECAP_PROFILE_EN
    logic [31:0] cyc_total, cyc_fft, cyc_synd, cyc_bm, cyc_loc;
`endif
    decap_stage_sequencer #(.m(13), .TO_W(20), .STAGE_TIMEOUT(20'd50)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
        .fail(fail), .fail_code(fail_code), .stage(stage),
        .fft_start(fft_start), .synd_start(synd_start), .bm_start(bm_start), .loc_start(loc_start),
        .fft_done(fft_done), .synd_done(synd_done), .bm_done(bm_done), .loc_done(loc_done),
        .loc_fail(loc_fail), .fft_rd_en(fft_rd_en), .fft_rd_addr(fft_rd_addr),
        .loc_rd_en(loc_rd_en), .loc_rd_addr(loc_rd_addr),
`ifdef DECAP_PROFILE_EN
        .cyc_total(cyc_total), .cyc_fft(cyc_fft), .cyc_synd(cyc_synd), .cyc_bm(cyc_bm), .cyc_loc(cyc_loc),
`endif
        .P_rd_en(P_rd_en), .P_rd_addr(P_rd_addr));

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int kind; int at; int code;} ev_t;
    ev_t q[$];
    int n_cmp = 0, n_bad = 0;
    bit mon_on = 1, rd_fix = 0;
    bit [3:0] sd [512];
    bit ss [512];
    bit sa [512];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rd_fix) begin
            fft_rd_en = 1'($urandom);
            loc_rd_en = 1'($urandom);
            fft_rd_addr = 13'($urandom);
            loc_rd_addr = 13'($urandom);
        end
    end

    // Monitor: pops an expected event whenever the DUT shows a pulse, and tracks owner/sticky status.
    int mstate = 0, mcode = 0;
    ev_t e;
    logic [4:0] p;
    initial forever begin
        @(negedge clk);
        #1;
        if (mon_on) begin
            if (mstate == 5) mstate = 0;
            p = {done, loc_start, bm_start, synd_start, fft_start};
            for (int k = 0; k < 5; k++) if (p[k]) begin
                if (q.size() == 0) chk("unexpected pulse", k, -1);
                else begin
                    e = q.pop_front();
                    chk("event kind", k, e.kind);
                    chk("event cycle", cyc, e.at);
                    if (e.kind == 0) mcode = 0;
                    if (e.kind == 4) begin
                        mcode = e.code;
                        mstate = 5;
                    end else mstate = e.kind + 1;
                end
            end
            chk("stage", int'(stage), mstate);
            chk("busy", int'(busy), int'(mstate >= 1 && mstate <= 4));
            chk("fail_code", int'(fail_code), mcode);
            chk("fail", int'(fail), int'(mcode != 0));
            chk("P_rd_en", int'(P_rd_en), (mstate == 1 || mstate == 2) ? int'(fft_rd_en) : mstate == 4 ? int'(loc_rd_en) : 0);
            chk("P_rd_addr", int'(P_rd_addr), (mstate == 1 || mstate == 2) ? int'(fft_rd_addr) : mstate == 4 ? int'(loc_rd_addr) : 0);
        end
    end

    // to_stg: stage that never gets done (-1 none); ab_stg/ab_off: abort in that stage at offset from its start.
    task automatic run(input int d0, d1, d2, d3, input bit lf, input int to_stg, input int ab_stg, input int ab_off, input bit noise);
        int d[4];
        int dur[4];
        int s, t, e_end, fin, code, j;
        d = '{d0, d1, d2, d3};
        dur = '{0, 0, 0, 0};
        for (int r = 0; r < 512; r++) begin
            sd[r] = 4'd0;
            ss[r] = 1'b0;
            sa[r] = 1'b0;
        end
        s = cyc;
        ss[0] = 1'b1;
        if (noise && $urandom_range(1, 0) == 1) sa[0] = 1'b1;
        t = 1;
        fin = -1;
        code = lf ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            q.push_back('{i, s + t, 0});
            if (noise && $urandom_range(3, 0) == 0) sd[t][i] = 1'b1;
            e_end = (i == ab_stg) ? t + ab_off : (i == to_stg) ? t + T : t + d[i];
            if (noise) for (int r = t; r <= e_end; r++) begin
                if ($urandom_range(7, 0) == 0) begin
                    j = (i + int'($urandom_range(3, 1))) % 4;
                    sd[r][j] = 1'b1;
                end
                if ($urandom_range(9, 0) == 0) ss[r] = 1'b1;
            end
            if (i == ab_stg) begin
                sa[e_end] = 1'b1;
                fin = e_end + 1;
                code = 3;
                dur[i] = ab_off + 1;
                sd[fin + 1][i] = 1'b1;
                break;
            end
            if (i == to_stg) begin
                fin = e_end + 1;
                code = 2;
                dur[i] = T + 1;
                break;
            end
            sd[e_end][i] = 1'b1;
            dur[i] = d[i] + 1;
            t = e_end + 1;
        end
        if (fin < 0) fin = t;
        if (noise) sa[fin + 2] = 1'b1;
        q.push_back('{4, s + fin, code});
        for (int r = 0; r <= fin + 4; r++) begin
            start = ss[r];
            abort = sa[r];
            {loc_done, bm_done, synd_done, fft_done} = sd[r];
            loc_fail = lf;
            @(negedge clk);
        end
        {start, abort, loc_done, bm_done, synd_done, fft_done} = 6'd0;
        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
        chk("leftover expected events", q.size(), 0);
        q.delete();
`ifdef DECAP_PROFILE_EN
        chk("cyc_fft", int'(cyc_fft), dur[0]);
        chk("cyc_synd", int'(cyc_synd), dur[1]);
        chk("cyc_bm", int'(cyc_bm), dur[2]);
        chk("cyc_loc", int'(cyc_loc), dur[3]);
        chk("cyc_total", int'(cyc_total), fin);
`endif
    endtask

    initial begin
        int d[4];
        int mode, k;
        repeat (2) @(negedge clk);
        chk("reset done", int'(done), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset P_rd_en", int'(P_rd_en), 0);
        rst_n = 1;
        repeat (2) @(negedge clk);
        rd_fix = 1;
        {fft_rd_en, loc_rd_en, fft_rd_addr, loc_rd_addr} = {2'b11, 13'h123, 13'h456};
        run(10, 20, 30, 40, 0, -1, -1, 0, 0);
        rd_fix = 0;
        run(10, 20, 30, 40, 1, -1, -1, 0, 0);
        run(10, 20, 30, 40, 0, -1, -1, 0, 0);
        run(10, 20, 30, 40, 0, 2, -1, 0, 0);
        run(10, 20, 30, 40, 0, -1, 1, 5, 0);
        run(10, 20, 30, 40, 0, -1, -1, 0, 1);
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) d[i] = int'($urandom_range(45, 1));
            mode = int'($urandom_range(2, 0));
            k = int'($urandom_range(3, 0));
            run(d[0], d[1], d[2], d[3], 1'($urandom), mode == 1 ? k : -1, mode == 2 ? k : -1,
                mode == 2 ? int'($urandom_range(d[k] - 1, 0)) : 0, 1);
        end
        mon_on = 0;
        rd_fix = 1;
        {fft_rd_en, loc_rd_en} = 2'b11;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        chk("busy before mid reset", int'(busy), 1);
        #2 rst_n = 0;
        #1;
        chk("mid reset stage", int'(stage), 0);
        chk("mid reset busy", int'(busy), 0);
        chk("mid reset P_rd_en", int'(P_rd_en), 0);
        chk("mid reset done", int'(done), 0);
        @(negedge clk);
        rst_n = 1;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk("no done after mid reset", int'(done), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
